mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 2, SHALL set the memory latency in cycles from mem_en assertion to valid mem_rdata; the legal range is 1..8.
REQ-002 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  in  1  SHALL be the reset: asynchronous, active-high.
REQ-004 if_req  in  1  SHALL be the instruction-fetch request, held high until if_ack.
REQ-005 if_addr  in  32  SHALL be the fetch address.
REQ-006 if_rdata  out  32  SHALL carry the fetched instruction word.
REQ-007 if_ack  out  1  SHALL be the one-cycle fetch completion pulse.
REQ-008 dm_req  in  1  SHALL be the data-memory request, held high until dm_ack.
REQ-009 dm_we  in  1  SHALL select the data access type: 1 = store, 0 = load.
REQ-010 dm_addr  in  32  SHALL be the data address.
REQ-011 dm_wdata  in  32  SHALL be the store data.
REQ-012 dm_rdata  out  32  SHALL carry the load data.
REQ-013 dm_ack  out  1  SHALL be the one-cycle data completion pulse.
REQ-014 mem_en, mem_we  out  1 each  SHALL be the shared memory enable and write strobe.
REQ-015 mem_addr, mem_wdata  out  32 each  SHALL be the shared memory address and write data.
REQ-016 mem_rdata  in  32  SHALL be the shared memory read data.
REQ-017 stall  out  1  SHALL be the pipeline freeze request.

Function
REQ-018 The FSM SHALL have three states: IDLE, BUSY and ACK.
REQ-019 IDLE SHALL behave as follows: if no request is pending, stay in IDLE; if any request is pending, grant one requester, register its addr/we/wdata and go to BUSY.
REQ-020 Arbitration SHALL be: single pending request wins; when both are pending, grant the requester not served last (last_grant register).
REQ-021 BUSY SHALL last exactly MEM_LAT cycles, driving mem_en=1, registered mem_addr/mem_wdata, and mem_we=1 only for a granted store.
REQ-022 In the final BUSY cycle, mem_rdata SHALL be captured into the granted requester's rdata register, loads and fetches only; stores SHALL leave dm_rdata unchanged.
REQ-023 ACK SHALL be a single cycle: granted ack=1, mem_en=0, next state IDLE.
REQ-024 No new grant SHALL occur in ACK.
REQ-025 Latency SHALL be MEM_LAT+2 cycles from the request being sampled in IDLE to the ack cycle (inclusive count: IDLE, BUSY×MEM_LAT, ACK).
REQ-026 A request deasserted or changed during BUSY SHALL be ignored; the transaction completes and ack still pulses.
REQ-027 if_rdata and dm_rdata SHALL hold their value until their next capture.
REQ-028 stall SHALL be combinational: (if_req & ~if_ack) | (dm_req & ~dm_ack).
REQ-029 The latency counter SHALL be 4 bits, load MEM_LAT-1 on entry to BUSY and decrement to 0 with no wrap.
REQ-030 mem_addr and mem_wdata SHALL read 0 outside BUSY.

Reset
REQ-031 While rst is high, outputs SHALL be: state IDLE, mem_en=0, mem_we=0, if_ack=0, dm_ack=0, mem_addr=0, mem_wdata=0, if_rdata=0, dm_rdata=0, last_grant=IF, counter=0.
REQ-032 Reset asserted during BUSY or ACK SHALL abort the transaction immediately, with no late ack after release.
REQ-033 The first cycle after reset release SHALL be IDLE with normal arbitration.

Structure
REQ-034 The state encoding, grant encoding (GNT_IF, GNT_DM) and MEM_LAT default SHALL reside in the shared mips_pkg package.
REQ-035 One sub-module, mem_lat_counter, SHALL be used for the load/decrement/zero-flag latency counter.

Verification
REQ-036 Reset: assert rst mid-run -> all outputs 0 the same cycle and stall equals its combinational value.
REQ-037 Fetch only, MEM_LAT=2: if_addr=0x00000004, mem_rdata=0x8C010014 in the 2nd BUSY cycle -> mem_en high 2 cycles, if_ack on cycle 4, if_rdata=0x8C010014, stall low the cycle after.
REQ-038 Simultaneous if_req and dm_req (load at 0x14, returning 0x8C020015) -> DM is granted first (last_grant=IF after reset), dm_ack on cycle 4, if_ack on cycle 8, stall high until cycle 8.
REQ-039 Store: dm_we=1, dm_addr=0x15, dm_wdata=0xDEADBEEF -> mem_we=1 for 2 cycles with matching mem_addr/mem_wdata, dm_ack pulses, dm_rdata unchanged.
REQ-040 Reset during the 1st BUSY cycle -> mem_en drops asynchronously and no ack occurs in the following 5 cycles with requests low.
REQ-041 Both requests held continuously for 20 cycles -> grants strictly alternate DM, IF, DM, IF, with one ack every 4 cycles.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the memory port arbiter
// Contents:
//    state_t     : arbiter FSM states (IDLE, BUSY, ACK)
//    gnt_t       : requester grant encoding (GNT_IF, GNT_DM)
//    MEM_LAT_DEF : default memory latency in cycles
package mips_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_DM = 1'b1
   } gnt_t;

   localparam int MEM_LAT_DEF = 2;

endpackage

// File: rtl/mem_lat_counter.sv
// rtl/mem_lat_counter.sv - 4-bit load/decrement latency counter with zero flag
// Ports:
//    clk    : clock, rising edge
//    rst    : asynchronous active-high reset (counter to 0)
//    load_i : load MEM_LAT-1
//    dec_i  : decrement by one, saturating at 0
//    zero_o : counter equals 0
module mem_lat_counter #(
   parameter int MEM_LAT = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   input  logic dec_i,
   output logic zero_o
);

   localparam logic [3:0] LOAD_VAL = 4'(MEM_LAT - 1);

   logic [3:0] cnt_q;
   logic [3:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = LOAD_VAL;
      end else if (dec_i && (cnt_q != 4'd0)) begin
         cnt_d = cnt_q - 4'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbitrates instruction fetch and data ports onto one memory
// Ports:
//    clk, rst                          : clock, asynchronous active-high reset
//    if_req, if_addr                   : fetch request (held until if_ack) and address
//    if_rdata, if_ack                  : fetched word, one-cycle completion pulse
//    dm_req, dm_we, dm_addr, dm_wdata  : data request (held until dm_ack), store flag, address, store data
//    dm_rdata, dm_ack                  : load data, one-cycle completion pulse
//    mem_en, mem_we, mem_addr,
//    mem_wdata, mem_rdata              : shared memory port
//    stall                             : pipeline freeze while any request is outstanding
module mem_port_arbiter
   import mips_pkg::*;
#(
   parameter int MEM_LAT = MEM_LAT_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ack,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic [31:0] dm_rdata,
   output logic        dm_ack,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        stall
);

   state_t      state_q, state_d;
   gnt_t        gnt_q, gnt_d;
   gnt_t        last_grant_q, last_grant_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        we_q, we_d;
   logic [31:0] if_rdata_q, if_rdata_d;
   logic [31:0] dm_rdata_q, dm_rdata_d;
   logic        cnt_load;
   logic        cnt_dec;
   logic        cnt_zero;
   gnt_t        sel;

   mem_lat_counter #(
      .MEM_LAT (MEM_LAT)
   ) u_lat_cnt (
      .clk    (clk),
      .rst    (rst),
      .load_i (cnt_load),
      .dec_i  (cnt_dec),
      .zero_o (cnt_zero)
   );

   always_comb begin
      state_d      = state_q;
      gnt_d        = gnt_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      we_d         = we_q;
      if_rdata_d   = if_rdata_q;
      dm_rdata_d   = dm_rdata_q;
      cnt_load     = 1'b0;
      cnt_dec      = 1'b0;
      sel          = GNT_IF;

      case (state_q)
         ST_IDLE: begin
            if (if_req || dm_req) begin
               // Contention goes to whoever was not served last.
               if (if_req && dm_req) begin
                  sel = (last_grant_q == GNT_IF) ? GNT_DM : GNT_IF;
               end else begin
                  sel = dm_req ? GNT_DM : GNT_IF;
               end
               gnt_d        = sel;
               last_grant_d = sel;
               if (sel == GNT_DM) begin
                  addr_d  = dm_addr;
                  we_d    = dm_we;
                  wdata_d = dm_wdata;
               end else begin
                  addr_d  = if_addr;
                  we_d    = 1'b0;
                  wdata_d = 32'd0;
               end
               cnt_load = 1'b1;
               state_d  = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (cnt_zero) begin
               // Final latency cycle: memory data is valid now.
               if (!we_q) begin
                  if (gnt_q == GNT_DM) begin
                     dm_rdata_d = mem_rdata;
                  end else begin
                     if_rdata_d = mem_rdata;
                  end
               end
               state_d = ST_ACK;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ST_ACK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         gnt_q        <= GNT_IF;
         last_grant_q <= GNT_IF;
         addr_q       <= 32'd0;
         wdata_q      <= 32'd0;
         we_q         <= 1'b0;
         if_rdata_q   <= 32'd0;
         dm_rdata_q   <= 32'd0;
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         we_q         <= we_d;
         if_rdata_q   <= if_rdata_d;
         dm_rdata_q   <= dm_rdata_d;
      end
   end

   // Memory-side outputs are gated by state so they read 0 outside BUSY.
   assign mem_en    = (state_q == ST_BUSY);
   assign mem_we    = mem_en & we_q;
   assign mem_addr  = mem_en ? addr_q  : 32'd0;
   assign mem_wdata = mem_en ? wdata_q : 32'd0;

   assign if_ack    = (state_q == ST_ACK) && (gnt_q == GNT_IF);
   assign dm_ack    = (state_q == ST_ACK) && (gnt_q == GNT_DM);
   assign if_rdata  = if_rdata_q;
   assign dm_rdata  = dm_rdata_q;

   assign stall     = (if_req & ~if_ack) | (dm_req & ~dm_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_ack;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        stall;

   int n_tests = 0;
   int n_fail  = 0;

   mem_port_arbiter #(.MEM_LAT(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_ack    (if_ack),
      .dm_req    (dm_req),
      .dm_we     (dm_we),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_rdata  (dm_rdata),
      .dm_ack    (dm_ack),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .stall     (stall)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge (start of a new cycle).
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Sample point in the middle of the current cycle.
   task automatic mid();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; if_req = 1'b0; if_addr = 32'd0; dm_req = 1'b0; dm_we = 1'b0;
      dm_addr = 32'd0; dm_wdata = 32'd0; mem_rdata = 32'd0;

      // Reset state
      mid();
      check_eq("rst_en",     {31'd0, mem_en}, 32'd0);
      check_eq("rst_we",     {31'd0, mem_we}, 32'd0);
      check_eq("rst_addr",   mem_addr, 32'd0);
      check_eq("rst_wdata",  mem_wdata, 32'd0);
      check_eq("rst_acks",   {30'd0, if_ack, dm_ack}, 32'd0);
      check_eq("rst_ifrd",   if_rdata, 32'd0);
      check_eq("rst_dmrd",   dm_rdata, 32'd0);
      check_eq("rst_stall",  {31'd0, stall}, 32'd0);
      step(); rst = 1'b0;

      // Fetch only
      step(); if_req = 1'b1; if_addr = 32'h0000_0004;             // cycle 1 IDLE
      mid(); check_eq("f_c1_en", {31'd0, mem_en}, 32'd0);
             check_eq("f_c1_stall", {31'd0, stall}, 32'd1);
      step();                                                      // cycle 2 BUSY
      mid(); check_eq("f_c2_en", {31'd0, mem_en}, 32'd1);
             check_eq("f_c2_addr", mem_addr, 32'h0000_0004);
             check_eq("f_c2_we", {31'd0, mem_we}, 32'd0);
      step(); mem_rdata = 32'h8C01_0014;                           // cycle 3 BUSY
      mid(); check_eq("f_c3_en", {31'd0, mem_en}, 32'd1);
             check_eq("f_c3_ack", {31'd0, if_ack}, 32'd0);
      step(); mem_rdata = 32'd0;                                   // cycle 4 ACK
      mid(); check_eq("f_c4_ack", {31'd0, if_ack}, 32'd1);
             check_eq("f_c4_en", {31'd0, mem_en}, 32'd0);
             check_eq("f_c4_addr", mem_addr, 32'd0);
             check_eq("f_c4_rd", if_rdata, 32'h8C01_0014);
             check_eq("f_c4_stall", {31'd0, stall}, 32'd0);
      step(); if_req = 1'b0;                                       // cycle 5
      mid(); check_eq("f_c5_ack", {31'd0, if_ack}, 32'd0);
             check_eq("f_c5_stall", {31'd0, stall}, 32'd0);
             check_eq("f_c5_rd", if_rdata, 32'h8C01_0014);

      // Simultaneous load and fetch: DM first, then IF
      step(); if_req = 1'b1; if_addr = 32'h0000_0008;
              dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0014;
      for (int c = 1; c <= 8; c++) begin
         if (c > 1) step();
         if (c == 3) mem_rdata = 32'h8C02_0015;
         else if (c == 7) mem_rdata = 32'h1111_1111;
         else mem_rdata = 32'd0;
         if (c == 5) dm_req = 1'b0;
         mid();
         check_eq($sformatf("s_c%0d_stall", c), {31'd0, stall}, (c < 8) ? 32'd1 : 32'd0);
         check_eq($sformatf("s_c%0d_dmack", c), {31'd0, dm_ack}, (c == 4) ? 32'd1 : 32'd0);
         check_eq($sformatf("s_c%0d_ifack", c), {31'd0, if_ack}, (c == 8) ? 32'd1 : 32'd0);
         if (c == 2) check_eq("s_c2_addr", mem_addr, 32'h0000_0014);
         if (c == 6) check_eq("s_c6_addr", mem_addr, 32'h0000_0008);
      end
      check_eq("s_dmrd", dm_rdata, 32'h8C02_0015);
      check_eq("s_ifrd", if_rdata, 32'h1111_1111);
      step(); if_req = 1'b0;

      // Store
      step(); dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0015;
              dm_wdata = 32'hDEAD_BEEF; mem_rdata = 32'h5555_5555;
      for (int c = 1; c <= 4; c++) begin
         if (c > 1) step();
         mid();
         check_eq($sformatf("w_c%0d_we", c), {31'd0, mem_we}, (c == 2 || c == 3) ? 32'd1 : 32'd0);
         check_eq($sformatf("w_c%0d_ack", c), {31'd0, dm_ack}, (c == 4) ? 32'd1 : 32'd0);
         if (c == 2 || c == 3) begin
            check_eq($sformatf("w_c%0d_addr", c), mem_addr, 32'h0000_0015);
            check_eq($sformatf("w_c%0d_wdata", c), mem_wdata, 32'hDEAD_BEEF);
         end
      end
      check_eq("w_dmrd", dm_rdata, 32'h8C02_0015);
      step(); dm_req = 1'b0; dm_we = 1'b0; mem_rdata = 32'd0;

      // Reset during first BUSY cycle
      step(); if_req = 1'b1; if_addr = 32'h0000_0020;
      step();
      mid(); check_eq("r_busy_en", {31'd0, mem_en}, 32'd1);
      #1 rst = 1'b1;
      #1 check_eq("r_async_en", {31'd0, mem_en}, 32'd0);
         check_eq("r_async_addr", mem_addr, 32'd0);
         check_eq("r_async_ifrd", if_rdata, 32'd0);
         check_eq("r_async_dmrd", dm_rdata, 32'd0);
         check_eq("r_async_stall", {31'd0, stall}, 32'd1);
      if_req = 1'b0;
      #1 check_eq("r_stall_low", {31'd0, stall}, 32'd0);
      step(); rst = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         mid();
         check_eq($sformatf("r_c%0d_acks", c), {30'd0, if_ack, dm_ack}, 32'd0);
         check_eq($sformatf("r_c%0d_en", c), {31'd0, mem_en}, 32'd0);
         step();
      end

      // Both held continuously: DM, IF, DM, IF, DM at cycles 4,8,12,16,20
      if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0;
      if_addr = 32'h0000_0100; dm_addr = 32'h0000_0200;
      for (int c = 1; c <= 20; c++) begin
         if (c > 1) step();
         mid();
         check_eq($sformatf("a_c%0d_dmack", c), {31'd0, dm_ack},
                  ((c % 4 == 0) && ((c / 4) % 2 == 1)) ? 32'd1 : 32'd0);
         check_eq($sformatf("a_c%0d_ifack", c), {31'd0, if_ack},
                  ((c % 4 == 0) && ((c / 4) % 2 == 0)) ? 32'd1 : 32'd0);
      end
      step(); if_req = 1'b0; dm_req = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
